// File: rtl/mem_wb_stage.sv
// uP16 MEM/WB stage: runs loads/stores on a ready/ack data bus, stalls upstream
// while memory is busy, aborts hung transactions, and drives RF write + forwarding.
module mem_wb_stage #(
    parameter int DSIZE   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EX_valid,
    input  logic [DSIZE-1:0] EX_ALUresult,
    input  logic [DSIZE-1:0] EX_storeData,
    input  logic [2:0]       EX_dest_rd,
    input  logic             EX_RFwriteEnab,
    input  logic             EX_memEnab,
    input  logic             EX_memWriteEnab,
    input  logic             EX_sel_mem2RF,
    input  logic             dmem_ack,
    input  logic [DSIZE-1:0] dmem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    output logic             stall,
    output logic             Mem_RFwriteEnab,
    output logic [2:0]       Mem_RFdest_rd,
    output logic [DSIZE-1:0] Mem_fwdData,
    output logic             RF_writeEnab,
    output logic [2:0]       WB_RFdest_rd,
    output logic [DSIZE-1:0] writeData,
    output logic             mem_err
);
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       ACCESS   = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic             M_valid;
    logic [DSIZE-1:0] M_ALUresult;
    logic [DSIZE-1:0] M_storeData;
    logic [2:0]       M_dest;
    logic             M_RFwriteEnab;
    logic             M_memEnab;
    logic             M_memWriteEnab;
    logic             M_sel_mem2RF;

    logic             W_valid;
    logic [2:0]       W_dest;
    logic             W_RFwriteEnab;
    logic             W_sel_mem2RF;
    logic [DSIZE-1:0] W_ALUresult;
    logic [DSIZE-1:0] W_memData;

    logic in_access;
    logic abort;
    logic complete;

    // An ack on the last allowed cycle wins over the abort.
    assign in_access = (state == ACCESS);
    assign abort     = in_access & (cnt == CNT_LAST) & ~dmem_ack;
    assign stall     = in_access & ~dmem_ack & ~abort;
    assign complete  = M_valid & (~M_memEnab | dmem_ack);

    // EX -> M boundary; the FSM advances with the M register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            M_valid        <= 1'b0;
            M_ALUresult    <= '0;
            M_storeData    <= '0;
            M_dest         <= '0;
            M_RFwriteEnab  <= 1'b0;
            M_memEnab      <= 1'b0;
            M_memWriteEnab <= 1'b0;
            M_sel_mem2RF   <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
        end else if (!stall) begin
            M_valid        <= EX_valid;
            M_ALUresult    <= EX_ALUresult;
            M_storeData    <= EX_storeData;
            M_dest         <= EX_dest_rd;
            M_RFwriteEnab  <= EX_RFwriteEnab;
            M_memEnab      <= EX_memEnab;
            M_memWriteEnab <= EX_memWriteEnab;
            M_sel_mem2RF   <= EX_sel_mem2RF;
            state          <= (EX_valid & EX_memEnab) ? ACCESS : IDLE;
            cnt            <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // M -> W boundary; only completed instructions reach writeback
    always_ff @(posedge Clk) begin
        if (Rst) begin
            W_valid       <= 1'b0;
            W_dest        <= '0;
            W_RFwriteEnab <= 1'b0;
            W_sel_mem2RF  <= 1'b0;
            W_ALUresult   <= '0;
            W_memData     <= '0;
        end else begin
            W_valid <= complete;
            if (complete) begin
                W_dest        <= M_dest;
                W_RFwriteEnab <= M_RFwriteEnab;
                W_sel_mem2RF  <= M_sel_mem2RF;
                W_ALUresult   <= M_ALUresult;
                W_memData     <= dmem_rdata;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst)        mem_err <= 1'b0;
        else if (abort) mem_err <= 1'b1;
    end

    assign dmem_req   = in_access;
    assign dmem_we    = in_access & M_memWriteEnab;
    assign dmem_addr  = M_ALUresult;
    assign dmem_wdata = M_storeData;

    // Loads are never forwarded from MEM; the hazard unit covers load-use.
    assign Mem_RFwriteEnab = M_valid & M_RFwriteEnab & ~M_sel_mem2RF;
    assign Mem_RFdest_rd   = M_dest;
    assign Mem_fwdData     = M_ALUresult;

    assign RF_writeEnab = W_valid & W_RFwriteEnab;
    assign WB_RFdest_rd = W_dest;
    assign writeData    = W_sel_mem2RF ? W_memData : W_ALUresult;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand sequences for timeout and
// reset-during-access, then randomized traffic against a transaction-level model.
module tb_mem_wb_stage;
    localparam int DSIZE = 16;
    localparam int TO    = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst;
    logic        EX_valid, EX_RFwriteEnab, EX_memEnab, EX_memWriteEnab, EX_sel_mem2RF;
    logic [15:0] EX_ALUresult, EX_storeData, dmem_rdata;
    logic [2:0]  EX_dest_rd;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, Mem_RFwriteEnab, RF_writeEnab, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, Mem_fwdData, writeData;
    logic [2:0]  Mem_RFdest_rd, WB_RFdest_rd;

    mem_wb_stage #(.DSIZE(DSIZE), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst),
        .EX_valid(EX_valid), .EX_ALUresult(EX_ALUresult), .EX_storeData(EX_storeData),
        .EX_dest_rd(EX_dest_rd), .EX_RFwriteEnab(EX_RFwriteEnab), .EX_memEnab(EX_memEnab),
        .EX_memWriteEnab(EX_memWriteEnab), .EX_sel_mem2RF(EX_sel_mem2RF),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .stall(stall), .Mem_RFwriteEnab(Mem_RFwriteEnab), .Mem_RFdest_rd(Mem_RFdest_rd),
        .Mem_fwdData(Mem_fwdData), .RF_writeEnab(RF_writeEnab), .WB_RFdest_rd(WB_RFdest_rd),
        .writeData(writeData), .mem_err(mem_err)
    );

    typedef struct {
        logic ev; logic [15:0] alu, sd; logic [2:0] rd;
        logic rfwe, men, mwe, sel, ack; logic [15:0] rdata;
    } in_t;
    typedef struct {
        logic req, we; logic [15:0] addr, dwd; logic stall, mfwe; logic [2:0] mfrd;
        logic [15:0] mfd; logic rfwe; logic [2:0] wbrd; logic [15:0] wd; logic err;
    } out_t;
    typedef struct { in_t i; out_t o; } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic in_t mk_in(int ev, int alu, int sd, int rd, int rfwe, int men,
                                  int mwe, int sel, int ack, int rdata);
        in_t r;
        r.ev = 1'(ev); r.alu = 16'(alu); r.sd = 16'(sd); r.rd = 3'(rd);
        r.rfwe = 1'(rfwe); r.men = 1'(men); r.mwe = 1'(mwe); r.sel = 1'(sel);
        r.ack = 1'(ack); r.rdata = 16'(rdata);
        return r;
    endfunction
    function automatic in_t i_bub(int ack, int rdata);
        return mk_in(0, 0, 0, 0, 0, 0, 0, 0, ack, rdata);
    endfunction
    function automatic in_t i_alu(int alu, int rd);
        return mk_in(1, alu, 0, rd, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic in_t i_lw(int addr, int rd, int ack, int rdata);
        return mk_in(1, addr, 0, rd, 1, 1, 0, 1, ack, rdata);
    endfunction
    function automatic in_t i_sw(int addr, int data, int ack);
        return mk_in(1, addr, data, 0, 0, 1, 1, 0, ack, 0);
    endfunction
    function automatic out_t o_mk(int req, int we, int addr, int dwd, int stl, int mfwe,
                                  int mfrd, int mfd, int rfwe, int wbrd, int wd, int err);
        out_t r;
        r.req = 1'(req); r.we = 1'(we); r.addr = 16'(addr); r.dwd = 16'(dwd);
        r.stall = 1'(stl); r.mfwe = 1'(mfwe); r.mfrd = 3'(mfrd); r.mfd = 16'(mfd);
        r.rfwe = 1'(rfwe); r.wbrd = 3'(wbrd); r.wd = 16'(wd); r.err = 1'(err);
        return r;
    endfunction
    function automatic out_t o_zero();
        return o_mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply_in(input in_t x);
        EX_valid = x.ev; EX_ALUresult = x.alu; EX_storeData = x.sd; EX_dest_rd = x.rd;
        EX_RFwriteEnab = x.rfwe; EX_memEnab = x.men; EX_memWriteEnab = x.mwe;
        EX_sel_mem2RF = x.sel; dmem_ack = x.ack; dmem_rdata = x.rdata;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, ".dmem_req"}, 32'(dmem_req), 32'(e.req));
        chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(e.we));
        chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
        chk({tag, ".Mem_RFwriteEnab"}, 32'(Mem_RFwriteEnab), 32'(e.mfwe));
        chk({tag, ".RF_writeEnab"}, 32'(RF_writeEnab), 32'(e.rfwe));
        chk({tag, ".mem_err"}, 32'(mem_err), 32'(e.err));
        if (e.req) chk({tag, ".dmem_addr"}, 32'(dmem_addr), 32'(e.addr));
        if (e.we)  chk({tag, ".dmem_wdata"}, 32'(dmem_wdata), 32'(e.dwd));
        if (e.mfwe) begin
            chk({tag, ".Mem_RFdest_rd"}, 32'(Mem_RFdest_rd), 32'(e.mfrd));
            chk({tag, ".Mem_fwdData"}, 32'(Mem_fwdData), 32'(e.mfd));
        end
        if (e.rfwe) begin
            chk({tag, ".WB_RFdest_rd"}, 32'(WB_RFdest_rd), 32'(e.wbrd));
            chk({tag, ".writeData"}, 32'(writeData), 32'(e.wd));
        end
    endtask

    // Transaction-level reference: the instruction sitting in MEM, how long it
    // has waited for memory, the last retired instruction, and the error flag.
    in_t         mdl_m;
    int          mdl_waited;
    in_t         mdl_w;
    logic [15:0] mdl_wmem;
    logic        mdl_wv;
    logic        mdl_err;

    function automatic out_t model_out(input in_t x);
        out_t e;
        bit busy, give_up;
        busy    = mdl_m.ev && mdl_m.men;
        give_up = busy && !x.ack && (mdl_waited >= TO - 1);
        e.req   = busy;
        e.we    = busy && mdl_m.mwe;
        e.addr  = mdl_m.alu;
        e.dwd   = mdl_m.sd;
        e.stall = busy && !x.ack && !give_up;
        e.mfwe  = mdl_m.ev && mdl_m.rfwe && !mdl_m.sel;
        e.mfrd  = mdl_m.rd;
        e.mfd   = mdl_m.alu;
        e.rfwe  = mdl_wv && mdl_w.rfwe;
        e.wbrd  = mdl_w.rd;
        e.wd    = mdl_w.sel ? mdl_wmem : mdl_w.alu;
        e.err   = mdl_err;
        return e;
    endfunction

    task automatic model_step(input in_t x, input logic rst, input out_t e);
        bit done;
        if (rst) begin
            mdl_m.ev = 1'b0; mdl_wv = 1'b0; mdl_err = 1'b0; mdl_waited = 0;
        end else begin
            done = mdl_m.ev && (!mdl_m.men || x.ack);
            if (done) begin
                mdl_w    = mdl_m;
                mdl_wmem = x.rdata;
            end
            mdl_wv = done;
            if (e.req && !x.ack && !e.stall) mdl_err = 1'b1;
            if (e.stall) mdl_waited++;
            else begin
                mdl_m      = x;
                mdl_waited = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        int   reqs, stalls;
        logic wb_seen, last_stall;
        in_t  ex, cur;
        out_t e;
        logic rst_i, prev_stall;

        // ADD, LW with 2 waits, zero-wait SW, then back-to-back LWs acked on cycle 2
        vq.push_back('{i_alu(16'h1234, 3), o_zero()});
        vq.push_back('{i_bub(0, 0), o_mk(0, 0, 0, 0, 0, 1, 3, 16'h1234, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h1234, 0)});
        vq.push_back('{i_lw(16'h0040, 2, 0, 0), o_zero()});
        vq.push_back('{i_bub(0, 0), o_mk(1, 0, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_mk(1, 0, 16'h0040, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(1, 16'hBEEF), o_mk(1, 0, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 16'hBEEF, 0)});
        vq.push_back('{i_sw(16'h0010, 16'h00AA, 0), o_zero()});
        vq.push_back('{i_bub(1, 0), o_mk(1, 1, 16'h0010, 16'h00AA, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_zero()});
        vq.push_back('{i_bub(0, 0), o_zero()});
        vq.push_back('{i_lw(16'h0100, 1, 0, 0), o_zero()});
        vq.push_back('{i_lw(16'h0200, 4, 0, 0), o_mk(1, 0, 16'h0100, 0, 1, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_lw(16'h0200, 4, 1, 16'h1111), o_mk(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_mk(1, 0, 16'h0200, 0, 1, 0, 0, 0, 1, 1, 16'h1111, 0)});
        vq.push_back('{i_bub(1, 16'h2222), o_mk(1, 0, 16'h0200, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{i_bub(0, 0), o_mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 16'h2222, 0)});
        vq.push_back('{i_bub(0, 0), o_zero()});

        Rst = 1'b1;
        apply_in(i_bub(0, 0));
        tick();
        @(negedge Clk);
        cmp_out("reset", o_zero());
        tick();
        Rst = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            apply_in(vq[k].i);
            @(negedge Clk);
            cmp_out($sformatf("vec%0d", k), vq[k].o);
            tick();
        end

        // Load that is never acknowledged
        apply_in(i_lw(16'h0080, 6, 0, 0));
        @(negedge Clk);
        tick();
        apply_in(i_bub(0, 0));
        reqs = 0; stalls = 0; wb_seen = 1'b0; last_stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (dmem_req) begin
                reqs++;
                if (reqs == TO) last_stall = stall;
            end
            if (stall) stalls++;
            if (RF_writeEnab) wb_seen = 1'b1;
            tick();
        end
        @(negedge Clk);
        chk("timeout.req_cycles", reqs, TO);
        chk("timeout.stall_cycles", stalls, TO - 1);
        chk("timeout.stall_on_abort", 32'(last_stall), 32'd0);
        chk("timeout.no_writeback", 32'(wb_seen), 32'd0);
        chk("timeout.mem_err", 32'(mem_err), 32'd1);
        tick();
        apply_in(i_alu(16'h5555, 5));
        @(negedge Clk);
        tick();
        apply_in(i_bub(0, 0));
        @(negedge Clk);
        cmp_out("after_timeout.m", o_mk(0, 0, 0, 0, 0, 1, 5, 16'h5555, 0, 0, 0, 1));
        tick();
        @(negedge Clk);
        cmp_out("after_timeout.w", o_mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 16'h5555, 1));
        tick();

        // Reset on the second ACCESS cycle of a load, followed by a late ack
        apply_in(i_lw(16'h0300, 7, 0, 0));
        @(negedge Clk);
        tick();
        apply_in(i_bub(0, 0));
        @(negedge Clk);
        chk("rst_access.req_c1", 32'(dmem_req), 32'd1);
        tick();
        Rst = 1'b1;
        @(negedge Clk);
        tick();
        Rst = 1'b0;
        apply_in(i_bub(1, 16'hDEAD));
        @(negedge Clk);
        cmp_out("rst_access.next", o_zero());
        tick();
        apply_in(i_bub(0, 0));
        @(negedge Clk);
        cmp_out("rst_access.after", o_zero());
        tick();

        // Randomized traffic; EX is held while the stage stalls, as upstream would
        Rst = 1'b1;
        apply_in(i_bub(0, 0));
        tick();
        Rst = 1'b0;
        mdl_m = i_bub(0, 0); mdl_w = i_bub(0, 0); mdl_wmem = '0;
        mdl_wv = 1'b0; mdl_err = 1'b0; mdl_waited = 0;
        prev_stall = 1'b0;
        ex = i_bub(0, 0);
        for (int n = 0; n < 3000; n++) begin
            if (!prev_stall)
                ex = mk_in(($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 65535)),
                           int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4) ? 1 : 0,
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 0);
            cur       = ex;
            cur.ack   = ($urandom_range(0, 99) < 30);
            cur.rdata = 16'($urandom);
            rst_i     = ($urandom_range(0, 199) == 0);
            apply_in(cur);
            Rst = rst_i;
            e = model_out(cur);
            @(negedge Clk);
            cmp_out($sformatf("rnd%0d", n), e);
            model_step(cur, rst_i, e);
            prev_stall = e.stall && !rst_i;
            tick();
        end
        Rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
